viterbi_traceback: RTL and testbench

- Survivor-memory and traceback stage of the K=7, 64-state Viterbi decoder in the convolutional decoding path.
- Stores the per-step 64-bit decision vectors produced by the add-compare-select array for one frame.
- Takes the best final state index produced by the path-metric selector stage.
- Traces back through the trellis and emits the decoded bits serially, in forward time order.

---
 rtl/viterbi_traceback.sv | 166 ++++++++++++++++
 tb/tb_viterbi_traceback.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for a K=7, 64-state Viterbi decoder.
// Stores one frame of decision vectors, traces back from the best final state, and emits the bits in forward order.
module viterbi_traceback #(
    parameter int NUM_STATES = 64,
    parameter int STATE_W    = 6,
    parameter int MAX_LEN    = 128,
    parameter int PTR_W      = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dec_valid,
    input  logic [NUM_STATES-1:0] i_dec_in,
    input  logic                  i_frame_end,
    input  logic                  i_best_valid,
    input  logic [STATE_W-1:0]    i_best_idx,
    output logic                  o_bit_out,
    output logic                  o_bit_valid,
    output logic                  o_frame_done,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_IDX,
        S_TRACE,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_STATES-1:0] r_mem [MAX_LEN];
    logic [MAX_LEN-1:0]    r_lifo;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_rd;
    logic [PTR_W:0]     r_len;
    logic [STATE_W-1:0] r_tstate;
    logic               r_bit_out;
    logic               r_bit_valid;
    logic               r_frame_done;
    logic               r_busy;

    logic                  w_accept;
    logic                  w_last_write;
    logic                  w_frame_close;
    logic [PTR_W-1:0]      w_wr_addr;
    logic [NUM_STATES-1:0] w_dec_word;
    logic                  w_pred_msb;
    logic                  w_last_bit;

    // r_busy stays high one cycle past OUTPUT so the final bit's cycle still blocks new writes.
    assign w_accept      = i_dec_valid && !r_busy && (r_state == S_IDLE || r_state == S_WRITE);
    assign w_last_write  = (r_state == S_WRITE) && (r_wr_ptr == PTR_W'(MAX_LEN - 1));
    assign w_frame_close = w_accept && (i_frame_end || w_last_write);
    assign w_wr_addr     = (r_state == S_IDLE) ? '0 : r_wr_ptr;
    assign w_dec_word    = r_mem[r_ptr];
    assign w_pred_msb    = w_dec_word[r_tstate];
    assign w_last_bit    = ({1'b0, r_rd} == (r_len - (PTR_W+1)'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_frame_close ? S_WAIT_IDX : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_frame_close) begin
                    w_next = S_WAIT_IDX;
                end
            end
            S_WAIT_IDX: begin
                if (i_best_valid) begin
                    w_next = S_TRACE;
                end
            end
            S_TRACE: begin
                if (r_ptr == '0) begin
                    w_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (w_last_bit) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Decision memory and bit LIFO carry no reset; they are always rewritten before being read.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= i_dec_in;
        end
        if (r_state == S_TRACE) begin
            r_lifo[r_ptr] <= r_tstate[0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_ptr        <= '0;
            r_rd         <= '0;
            r_len        <= '0;
            r_tstate     <= '0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= (w_next == S_WAIT_IDX) || (w_next == S_TRACE) ||
                            (w_next == S_OUTPUT) || (r_state == S_OUTPUT);
            unique case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_accept) begin
                        r_wr_ptr <= w_wr_addr + PTR_W'(1);
                    end
                    if (w_frame_close) begin
                        r_wr_ptr <= '0;
                        r_len    <= {1'b0, w_wr_addr} + (PTR_W+1)'(1);
                    end
                end
                S_WAIT_IDX: begin
                    if (i_best_valid) begin
                        r_tstate <= i_best_idx;
                        r_ptr    <= r_len[PTR_W-1:0] - PTR_W'(1);
                    end
                end
                S_TRACE: begin
                    r_tstate <= {w_pred_msb, r_tstate[STATE_W-1:1]};
                    r_ptr    <= r_ptr - PTR_W'(1);
                    r_rd     <= '0;
                end
                S_OUTPUT: begin
                    r_bit_out    <= r_lifo[r_rd];
                    r_bit_valid  <= 1'b1;
                    r_rd         <= r_rd + PTR_W'(1);
                    r_frame_done <= w_last_bit;
                end
                default: ;
            endcase
        end
    end

    assign o_bit_out    = r_bit_out;
    assign o_bit_valid  = r_bit_valid;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: random and directed frames compared
// against a straightforward arithmetic traceback model.
module tb_viterbi_traceback;

    logic        clk = 1'b0;
    logic        rst;
    logic        decValid;
    logic [63:0] decIn;
    logic        frameEnd;
    logic        bestValid;
    logic [5:0]  bestIdx;
    logic        bitOut;
    logic        bitValid;
    logic        frameDone;
    logic        busy;

    int vectorCount = 0;
    int missCount   = 0;

    logic [63:0] decMem  [128];
    logic        expBits [128];

    localparam int PAT_ZERO = 0;
    localparam int PAT_ONES = 1;
    localparam int PAT_RAND = 2;

    always #5 clk = ~clk;

    viterbi_traceback dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_dec_valid  (decValid),
        .i_dec_in     (decIn),
        .i_frame_end  (frameEnd),
        .i_best_valid (bestValid),
        .i_best_idx   (bestIdx),
        .o_bit_out    (bitOut),
        .o_bit_valid  (bitValid),
        .o_frame_done (frameDone),
        .o_busy       (busy)
    );

    // Advance one clock and settle just past the edge, where inputs are driven and outputs sampled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: walk the survivor path backwards with plain arithmetic on state numbers.
    task automatic buildModel(input int n, input int best);
        int s;
        s = best;
        for (int t = n - 1; t >= 0; t--) begin
            expBits[t] = logic'(s % 2);
            s = (decMem[t][s] ? 32 : 0) + s / 2;
        end
    endtask

    task automatic fillDecisions(input int n, input int pattern);
        for (int t = 0; t < n; t++) begin
            case (pattern)
                PAT_ZERO: decMem[t] = '0;
                PAT_ONES: decMem[t] = '1;
                default:  decMem[t] = {$urandom, $urandom};
            endcase
        end
    endtask

    task automatic driveFrame(input int n, input logic [5:0] best, input bit earlyBest,
                              input bit simulBest, input bit forceOverflow);
        for (int t = 0; t < n; t++) begin
            decValid  = 1'b1;
            decIn     = decMem[t];
            frameEnd  = forceOverflow ? 1'b0 : (t == n - 1);
            bestValid = (earlyBest && t == n / 2 && t != n - 1) || (simulBest && t == n - 1);
            bestIdx   = ~best;
            tick();
        end
        decValid  = 1'b0;
        frameEnd  = 1'b0;
        bestValid = 1'b0;
        checkOutput("busy_after_frame_end", 32'(busy), 32'd1);
        if (forceOverflow) begin
            decValid = 1'b1;
            decIn    = {$urandom, $urandom};
            frameEnd = 1'b1;
            tick();
            decValid = 1'b0;
            frameEnd = 1'b0;
            checkOutput("busy_after_ignored_beat", 32'(busy), 32'd1);
        end
    endtask

    task automatic applyStimulus(input int n, input int pattern, input logic [5:0] best,
                                 input bit earlyBest, input bit simulBest, input bit dupBest,
                                 input bit forceOverflow);
        int k;
        fillDecisions(n, pattern);
        buildModel(n, int'(best));
        driveFrame(n, best, earlyBest, simulBest, forceOverflow);
        repeat ($urandom_range(0, 3)) tick();
        bestValid = 1'b1;
        bestIdx   = best;
        tick();
        k = 0;
        if (dupBest) begin
            bestIdx = ~best;
            tick();
            k = 1;
        end
        bestValid = 1'b0;
        while (!bitValid && k < n + 10) begin
            tick();
            k++;
        end
        checkOutput($sformatf("first_bit_latency_n%0d", n), 32'(k), 32'(n + 1));
        if (bitValid) begin
            for (int i = 0; i < n; i++) begin
                checkOutput($sformatf("bit_valid_n%0d[%0d]", n, i), 32'(bitValid), 32'd1);
                checkOutput($sformatf("bit_out_n%0d[%0d]", n, i), 32'(bitOut), 32'(expBits[i]));
                checkOutput($sformatf("frame_done_n%0d[%0d]", n, i), 32'(frameDone), 32'(i == n - 1));
                checkOutput($sformatf("busy_n%0d[%0d]", n, i), 32'(busy), 32'd1);
                tick();
            end
        end
        checkOutput("bit_valid_after_frame", 32'(bitValid), 32'd0);
        checkOutput("frame_done_after_frame", 32'(frameDone), 32'd0);
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        decValid  = 1'b0;
        decIn     = '0;
        frameEnd  = 1'b0;
        bestValid = 1'b0;
        bestIdx   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_bit_valid", 32'(bitValid), 32'd0);
        checkOutput("reset_frame_done", 32'(frameDone), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_bit_out", 32'(bitOut), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] directed frames");
        applyStimulus(8, PAT_ZERO, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(6, PAT_ZERO, 6'b101101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8, PAT_ONES, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(128, PAT_RAND, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset during traceback");
        fillDecisions(6, PAT_ZERO);
        driveFrame(6, 6'b101101, 1'b0, 1'b0, 1'b0);
        bestValid = 1'b1;
        bestIdx   = 6'b101101;
        tick();
        bestValid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        checkOutput("midtrace_rst_bit_valid", 32'(bitValid), 32'd0);
        checkOutput("midtrace_rst_frame_done", 32'(frameDone), 32'd0);
        checkOutput("midtrace_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        applyStimulus(6, PAT_ZERO, 6'b101101, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(3, PAT_ZERO, 6'b000001, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] boundary and random frames");
        applyStimulus(1, PAT_RAND, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(128, PAT_RAND, 6'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 14; f++) begin
            applyStimulus(int'($urandom_range(1, 128)), PAT_RAND, 6'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
